// File: rtl/aw_split_ctrl.sv
// aw_split_ctrl: write-address sequencer for the wide-to-narrow AXI data-width adapter.
//
// Accepts one slave-side AW burst, rescales it to narrow (master) beats and issues
// it as up to four master-side sub-bursts of at most 256 beats each. The first
// sub-AW handshake pushes {awid, N} into the B-response tracker.
//
// Optional feature macro: AW_SPLIT_OUTST_LIMIT_EN
//   defined   -> counts outstanding parent bursts (+1 per accept, -1 per rd_valid)
//                and holds s_awready low while the count equals MAX_OUTST.
//   undefined -> no counter; s_awready depends only on the FSM; rd_valid unused.
//
// Ports:
//   aclk, arst_n       clock, asynchronous active-low reset
//   s_aw*              slave-side AW channel (wide beats)
//   m_aw*              master-side AW channel (narrow sub-bursts)
//   m_aw_handshake     1-cycle push strobe on the first sub-AW handshake
//   total_sub_txn      number of sub-bursts N, valid with m_aw_handshake
//   rd_valid           tracker completion pulse (one parent finished)
//   err_unsupported    1-cycle pulse after accepting a non-INCR burst that needs scaling
//   busy               sequencer is issuing sub-bursts
module aw_split_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned AWID_WIDTH   = 3,
  parameter int unsigned S_DATA_WIDTH = 64,
  parameter int unsigned M_DATA_WIDTH = 32,
  parameter int unsigned MAX_OUTST    = 4
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic [AWID_WIDTH-1:0] s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  output logic [AWID_WIDTH-1:0] m_awid,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic                  m_aw_handshake,
  output logic [2:0]            total_sub_txn,
  input  logic                  rd_valid,
  output logic                  err_unsupported,
  output logic                  busy
);

  localparam int unsigned MBytes    = M_DATA_WIDTH / 8;
  localparam int unsigned MSize     = $clog2(MBytes);
  localparam int unsigned MaxShift  = $clog2(S_DATA_WIDTH / M_DATA_WIDTH);
  // Byte distance between consecutive sub-burst start addresses (256 narrow beats).
  localparam int unsigned StrideLog = 8 + MSize;

  localparam logic [2:0]            MSizeL    = 3'(MSize);
  localparam logic [2:0]            MaxShiftL = 3'(MaxShift);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(MBytes - 1);
  localparam logic [1:0]            BurstIncr = 2'b01;

  // Elaboration-time range checks on the configuration.
  if (MAX_OUTST < 1 || MAX_OUTST > 7) begin : g_bad_outst
    $error("MAX_OUTST must be in 1..7");
  end
  if (S_DATA_WIDTH < M_DATA_WIDTH || S_DATA_WIDTH > 4 * M_DATA_WIDTH) begin : g_bad_ratio
    $error("S_DATA_WIDTH/M_DATA_WIDTH must be 1, 2 or 4");
  end

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } state_e;

  state_e                  state_q, state_d;
  logic [AWID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic [2:0]              n_q, n_d;
  logic [2:0]              k_q, k_d;
  logic [10:0]             rem_q, rem_d;
  logic                    err_q, err_d;
  logic                    ready_en_q;

  logic                    outst_ok;
  logic                    s_hs;
  logic                    m_hs;

  // ---------------------------------------------------------------------------
  // Accept-side burst scaling
  // ---------------------------------------------------------------------------
  logic                    size_gt;
  logic [2:0]              shift;
  logic [10:0]             beats;
  logic                    unsplit;
  logic [2:0]              n_calc;
  logic [7:0]              len_calc;
  logic [2:0]              size_calc;

  assign size_gt = s_awsize > MSizeL;

  // Clamp so an out-of-range s_awsize cannot overflow the beat count.
  always_comb begin
    shift = 3'd0;
    if (size_gt) begin
      shift = s_awsize - MSizeL;
      if (shift > MaxShiftL) begin
        shift = MaxShiftL;
      end
    end
  end

  assign beats     = ({3'b000, s_awlen} + 11'd1) << shift;
  // FIXED/WRAP bursts cannot be rescaled; they go out untouched as one sub-burst.
  assign unsplit   = (s_awburst != BurstIncr) && size_gt;
  assign n_calc    = unsplit ? 3'd1 : 3'((beats + 11'd255) >> 8);
  assign len_calc  = unsplit ? s_awlen
                   : (beats > 11'd256) ? 8'd255 : 8'(beats - 11'd1);
  assign size_calc = (size_gt && !unsplit) ? MSizeL : s_awsize;

  // ---------------------------------------------------------------------------
  // Issue-side sub-burst sequencing
  // ---------------------------------------------------------------------------
  logic                    last_sub;
  logic [2:0]              k_next;
  logic [10:0]             rem_next;
  logic [7:0]              len_next;
  logic [ADDR_WIDTH-1:0]   addr_next;

  assign last_sub  = (k_q + 3'd1) == n_q;
  assign k_next    = k_q + 3'd1;
  // A non-last sub-burst always carries exactly 256 beats.
  assign rem_next  = rem_q - 11'd256;
  assign len_next  = (rem_next > 11'd256) ? 8'd255 : 8'(rem_next - 11'd1);
  assign addr_next = base_q + (ADDR_WIDTH'(k_next) << StrideLog);

  // ---------------------------------------------------------------------------
  // Outstanding parent limit
  // ---------------------------------------------------------------------------
`ifdef AW_SPLIT_OUTST_LIMIT_EN
  logic [2:0] outst_q, outst_d;
  logic       rd_dec;

  // A completion with nothing outstanding is a tracker glitch; ignore it.
  assign rd_dec = rd_valid && (outst_q != 3'd0);

  always_comb begin
    outst_d = outst_q;
    if (s_hs && !rd_dec) begin
      outst_d = outst_q + 3'd1;
    end else if (!s_hs && rd_dec) begin
      outst_d = outst_q - 3'd1;
    end
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      outst_q <= 3'd0;
    end else begin
      outst_q <= outst_d;
    end
  end

  assign outst_ok = outst_q < 3'(MAX_OUTST);
`else
  logic unused_rd_valid;
  assign unused_rd_valid = rd_valid;
  assign outst_ok        = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // ready_en_q keeps s_awready low for the first cycle out of reset.
  assign s_awready = ready_en_q && (state_q == StIdle) && outst_ok;
  assign m_awvalid = state_q == StIssue;
  assign busy      = state_q != StIdle;
  assign s_hs      = s_awvalid && s_awready;
  assign m_hs      = m_awvalid && m_awready;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    n_d     = n_q;
    k_d     = k_q;
    rem_d   = rem_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s_hs) begin
          state_d = StIssue;
          id_d    = s_awid;
          addr_d  = s_awaddr;
          base_d  = s_awaddr & AlignMask;
          len_d   = len_calc;
          size_d  = size_calc;
          burst_d = s_awburst;
          n_d     = n_calc;
          k_d     = 3'd0;
          rem_d   = beats;
          err_d   = unsplit;
        end
      end
      StIssue: begin
        if (m_hs) begin
          if (last_sub) begin
            state_d = StIdle;
          end else begin
            k_d    = k_next;
            rem_d  = rem_next;
            addr_d = addr_next;
            len_d  = len_next;
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      n_q        <= '0;
      k_q        <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      n_q        <= n_d;
      k_q        <= k_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  assign m_awid          = id_q;
  assign m_awaddr        = addr_q;
  assign m_awlen         = len_q;
  assign m_awsize        = size_q;
  assign m_awburst       = burst_q;
  assign err_unsupported = err_q;
  // Tracker push: only the first sub-burst handshake of a parent.
  assign m_aw_handshake  = m_hs && (k_q == 3'd0);
  assign total_sub_txn   = m_aw_handshake ? n_q : 3'd0;

endmodule

// File: doc/aw_split_ctrl.md
Name: aw_split_ctrl

Overview:
Write-address sequencer on the wide-to-narrow write path of the AXI data-width adapter. It accepts one slave-side AW burst, scales it to narrow-beat units and issues it as N master-side sub-bursts of at most 256 beats each. On the first sub-AW handshake it pushes {awid, N} into the B-response tracker (the awid block), and it limits outstanding parent transactions.

Parameters:
ADDR_WIDTH, 32, address width
AWID_WIDTH, 3, ID width (matches tracker)
S_DATA_WIDTH, 64, slave data width in bits
M_DATA_WIDTH, 32, master data width in bits; S/M ratio is a power of 2 in 1..4
MAX_OUTST, 4, max outstanding parent transactions, 1..7

Ports:
aclk  in  1  clock
arst_n  in  1  async active-low reset
s_awid  in  AWID_WIDTH  slave AW ID
s_awaddr  in  ADDR_WIDTH  slave AW address
s_awlen  in  8  slave burst length-1
s_awsize  in  3  slave beat size (log2 bytes)
s_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP
s_awvalid  in  1  slave AW valid
s_awready  out  1  slave AW ready
m_awid  out  AWID_WIDTH  sub-burst ID (= parent ID)
m_awaddr  out  ADDR_WIDTH  sub-burst address
m_awlen  out  8  sub-burst length-1
m_awsize  out  3  sub-burst size
m_awburst  out  2  sub-burst type
m_awvalid  out  1  master AW valid
m_awready  in  1  master AW ready
m_aw_handshake  out  1  1-cycle push strobe to tracker, on first sub-AW handshake only
total_sub_txn  out  3  N, valid while m_aw_handshake=1
rd_valid  in  1  tracker completion pulse (one parent finished)
err_unsupported  out  1  1-cycle pulse, unsplittable burst accepted
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: s_awready=0, m_awvalid=0, all m_aw* fields=0, m_aw_handshake=0, total_sub_txn=0, err_unsupported=0, busy=0, outstanding count=0, FSM=IDLE.
- MSIZE = log2(M_DATA_WIDTH/8). mult = 2^(s_awsize-MSIZE) when s_awsize>MSIZE, else 1.
- beats = (s_awlen+1)*mult (11-bit). N = ceil(beats/256), range 1..4.
- FSM IDLE: s_awready = (outst < MAX_OUTST). On s_awvalid&s_awready, register the fields, compute N, go to ISSUE. s_awready is 0 in ISSUE.
- FSM ISSUE: m_awvalid=1 starting the cycle after the s_aw handshake (1-cycle latency).
  - Sub k: len = min(remaining,256)-1, size = min(s_awsize,MSIZE), burst = s_awburst, id = s_awid.
  - Addr: k=0 uses s_awaddr unchanged. k>0 uses (s_awaddr aligned down to M bytes) + k*256*(M_DATA_WIDTH/8).
- m_aw* fields are held stable while m_awvalid=1 and m_awready=0.
- On m_awvalid&m_awready: if last sub, return to IDLE (m_awvalid=0 next cycle); else advance k and subtract the issued beats from remaining. No idle cycle between consecutive sub-AWs.
- m_aw_handshake and total_sub_txn are combinational from the k=0 handshake: asserted in that same cycle, total_sub_txn=N. For N=1, total_sub_txn=1.
- Non-INCR burst with s_awsize>MSIZE: pulse err_unsupported the cycle after accept. Forward as a single sub-burst (N=1) with the fields unchanged.
- Outstanding counter:
  - +1 on s_aw handshake, -1 on rd_valid; both in the same cycle leaves it unchanged.
  - rd_valid while the count is 0 is ignored.
  - s_awready drops combinationally when the count equals MAX_OUTST.
- Reset asserted mid-ISSUE: FSM returns to IDLE immediately and all outputs go to reset values. The partial burst is dropped with no further sub-AWs.

Optional Feature:
AW_SPLIT_OUTST_LIMIT_EN: defined -> outstanding counter and MAX_OUTST gating active as described. Undefined -> no counter; s_awready = (FSM==IDLE); rd_valid ignored; MAX_OUTST unused.

Test Plan:
- INCR, s_awsize=3, s_awlen=255, addr 0x1000 -> two sub-AWs: (0x1000, len 255, size 2) and (0x1400, len 255, size 2); m_aw_handshake once with total_sub_txn=2.
- INCR, s_awsize=3, s_awlen=3, addr 0x20 -> one sub-AW (0x20, len 7, size 2); total_sub_txn=1; m_awvalid high 1 cycle after accept.
- INCR, s_awsize=2, s_awlen=15 -> pass-through (len 15, size 2), N=1; then m_awready held low 5 cycles -> all m_aw* fields stable, single handshake.
- MAX_OUTST=2 with macro defined -> third s_awvalid sees s_awready=0 until rd_valid pulses, then accepted next IDLE cycle. Simultaneous accept+rd_valid -> count unchanged.
- WRAP, s_awsize=3, s_awlen=3 -> err_unsupported pulse, one sub-AW with fields unchanged (len 3, size 3).
- arst_n low during the 2nd sub-AW of an N=2 burst -> m_awvalid=0, busy=0, s_awready=0 while in reset, and no further sub-AWs after release.
